// File: rtl/el2_dec_trigger_csr_pkg.sv
// Shared trigger packet type, trigger CSR addresses and mcontrol field layout.
// Chain support is compiled in with RV_TRIGGER_CHAIN_EN.
package el2_dec_trigger_csr_pkg;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } el2_trigger_pkt_t;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

    // mcontrol bit positions (multi-bit fields give their low bit)
    localparam int MC_LOAD    = 0;
    localparam int MC_STORE   = 1;
    localparam int MC_EXECUTE = 2;
    localparam int MC_M       = 6;
    localparam int MC_MATCH   = 7;
    localparam int MC_CHAIN   = 11;
    localparam int MC_ACTION  = 12;
    localparam int MC_SELECT  = 19;
    localparam int MC_HIT     = 20;
    localparam int MC_DMODE   = 27;

    localparam logic [3:0] MCONTROL_TYPE = 4'h2;
    localparam logic [5:0] MAXMASK       = 6'h1F;

`ifdef RV_TRIGGER_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

endpackage

// File: rtl/el2_trigger_csr_entry.sv
// One trigger slot: tdata1/tdata2 registers with write lock and legalisation, sticky hit, packet.
// Writes land next cycle; packet and readback are combinational; no backpressure.
module el2_trigger_csr_entry
    import el2_dec_trigger_csr_pkg::*;
#(
    parameter bit CHAIN_WRITABLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             dbg_mode,
    input  logic             wr_tdata1,
    input  logic             wr_tdata2,
    input  logic [31:0]      wdata,
    input  logic             hit_set,
    output logic [31:0]      tdata1,
    output logic [31:0]      tdata2,
    output el2_trigger_pkt_t pkt,
    output logic             action,
    output logic             chain
);

    logic dmode, hit, select, match, m, execute, store, load;
    logic lock, new_dmode;

    // A debugger-owned trigger cannot be rewritten from machine mode
    assign lock      = dmode & ~dbg_mode;
    assign new_dmode = wdata[MC_DMODE] & dbg_mode;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dmode   <= 1'b0;
            action  <= 1'b0;
            hit     <= 1'b0;
            select  <= 1'b0;
            chain   <= 1'b0;
            match   <= 1'b0;
            m       <= 1'b0;
            execute <= 1'b0;
            store   <= 1'b0;
            load    <= 1'b0;
            tdata2  <= 32'h0;
        end else begin
            if (wr_tdata1 && !lock) begin
                dmode   <= new_dmode;
                action  <= new_dmode & (wdata[MC_ACTION+3:MC_ACTION] == 4'h1);
                hit     <= wdata[MC_HIT] | hit_set;
                select  <= wdata[MC_SELECT];
                chain   <= CHAIN_EN & CHAIN_WRITABLE & wdata[MC_CHAIN];
                match   <= (wdata[MC_MATCH+3:MC_MATCH+1] == 3'b000) & wdata[MC_MATCH];
                m       <= wdata[MC_M];
                execute <= wdata[MC_EXECUTE];
                store   <= wdata[MC_STORE];
                load    <= wdata[MC_LOAD];
            end else if (hit_set) begin
                hit <= 1'b1;
            end
            if (wr_tdata2 && !lock) begin
                tdata2 <= wdata;
            end
        end
    end

    assign tdata1 = {MCONTROL_TYPE, dmode, MAXMASK, hit, select, 1'b0, 2'b00,
                     {3'b000, action}, chain, 3'b000, match, m, 1'b0, 1'b0, 1'b0,
                     execute, store, load};

    assign pkt.select  = select;
    assign pkt.match   = match;
    assign pkt.store   = store & m & ~dbg_mode;
    assign pkt.load    = load & m & ~dbg_mode;
    assign pkt.execute = execute & m & ~dbg_mode;
    assign pkt.m       = m;
    assign pkt.tdata2  = tdata2;

endmodule

// File: rtl/el2_dec_trigger_csr.sv
// Trigger CSR bank and hit handler (chain pairing with RV_TRIGGER_CHAIN_EN).
// match_m -> hit/exception/halt one cycle later; CSR writes visible next cycle; no backpressure.
module el2_dec_trigger_csr
    import el2_dec_trigger_csr_pkg::*;
#(
    parameter int          NUM_TRIGGERS = 4,
    parameter logic [11:0] TSELECT_ADDR = CSR_TSELECT
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    dbg_mode,
    input  logic                    csr_wen,
    input  logic [11:0]             csr_waddr,
    input  logic [31:0]             csr_wdata,
    input  logic [11:0]             csr_raddr,
    output logic [31:0]             csr_rdata,
    input  logic [NUM_TRIGGERS-1:0] lsu_trigger_match_m,
    input  logic                    flush_m,
    input  logic                    i0_valid_r,
    input  logic                    flush_r,
    input  logic                    dbg_halt_ack,
    output el2_trigger_pkt_t        trigger_pkt_any [NUM_TRIGGERS],
    output logic [NUM_TRIGGERS-1:0] trigger_hit_r,
    output logic                    trigger_exc_r,
    output logic                    trigger_dbg_halt_req
);

    localparam int          SEL_W       = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;
    localparam logic [11:0] TDATA1_ADDR = TSELECT_ADDR + 12'd1;
    localparam logic [11:0] TDATA2_ADDR = TSELECT_ADDR + 12'd2;

    logic [SEL_W-1:0]        tselect;
    logic [NUM_TRIGGERS-1:0] match_r, chain_qual, action, chain;
    logic [31:0]             tdata1_all [NUM_TRIGGERS];
    logic [31:0]             tdata2_all [NUM_TRIGGERS];
    logic                    halt_q, halt_set;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tselect <= '0;
        end else if (csr_wen && csr_waddr == TSELECT_ADDR && csr_wdata[31:SEL_W] == '0) begin
            tselect <= csr_wdata[SEL_W-1:0];
        end
    end

    for (genvar i = 0; i < NUM_TRIGGERS; i++) begin : g_entry
        logic wr1, wr2;
        assign wr1 = csr_wen & (csr_waddr == TDATA1_ADDR) & (tselect == SEL_W'(i));
        assign wr2 = csr_wen & (csr_waddr == TDATA2_ADDR) & (tselect == SEL_W'(i));

        el2_trigger_csr_entry #(
            .CHAIN_WRITABLE((i % 2 == 0) && (i + 1 < NUM_TRIGGERS))
        ) u_entry (
            .clk       (clk),
            .rst_l     (rst_l),
            .dbg_mode  (dbg_mode),
            .wr_tdata1 (wr1),
            .wr_tdata2 (wr2),
            .wdata     (csr_wdata),
            .hit_set   (trigger_hit_r[i]),
            .tdata1    (tdata1_all[i]),
            .tdata2    (tdata2_all[i]),
            .pkt       (trigger_pkt_any[i]),
            .action    (action[i]),
            .chain     (chain[i])
        );

        // A chained pair only hits when both halves matched the same access
        localparam int LEAD = i - (i % 2);
        if (LEAD + 1 < NUM_TRIGGERS) begin : g_pair
            assign chain_qual[i] = ~chain[LEAD] | (match_r[LEAD] & match_r[LEAD+1]);
        end else begin : g_single
            assign chain_qual[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            match_r <= '0;
        end else begin
            match_r <= lsu_trigger_match_m & {NUM_TRIGGERS{~flush_m}};
        end
    end

    assign trigger_hit_r = match_r & {NUM_TRIGGERS{i0_valid_r & ~flush_r}} & chain_qual;
    assign trigger_exc_r = |(trigger_hit_r & ~action);
    assign halt_set      = |(trigger_hit_r & action);

    // Request is visible in the hit cycle and held until the debugger acknowledges
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            halt_q <= 1'b0;
        end else if (dbg_halt_ack) begin
            halt_q <= 1'b0;
        end else if (halt_set) begin
            halt_q <= 1'b1;
        end
    end

    assign trigger_dbg_halt_req = halt_q | halt_set;

    always_comb begin
        csr_rdata = 32'h0;
        if (csr_raddr == TSELECT_ADDR) begin
            csr_rdata = 32'(tselect);
        end else if (csr_raddr == TDATA1_ADDR) begin
            csr_rdata = tdata1_all[tselect];
        end else if (csr_raddr == TDATA2_ADDR) begin
            csr_rdata = tdata2_all[tselect];
        end
    end

endmodule
